// File: rtl/prg_saver.sv
// Streams a PET BASIC program out of RAM to the HPS as a .PRG file (2-byte load address + body).
// Optional: define PRG_SAVE_CPU_HOLD_EN to freeze the CPU via cpu_hold for the whole upload session.
module prg_saver #(
  parameter int          RAM_LAT  = 1,
  parameter logic [15:0] RAM_TOP  = 16'h8000,
  parameter logic [15:0] PTR_BASE = 16'h0028
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ioctl_upload,
  input  logic        ioctl_rd,
  input  logic [24:0] ioctl_addr,
  output logic [7:0]  ioctl_din,
  output logic        ioctl_wait,
  output logic [15:0] dma_addr,
  output logic        dma_rd,
  input  logic [7:0]  dma_din,
  output logic [15:0] file_size,
  output logic        ready,
  output logic        bad_ptr,
  output logic        cpu_hold
);

  typedef enum logic [2:0] {S_IDLE, S_PTR, S_READY, S_FETCH, S_WAIT, S_RESP} state_t;

  localparam logic [7:0] LAT = 8'(RAM_LAT);

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  lat_q, lat_d;
  logic [15:0] start_q, start_d;
  logic [7:0]  end_lo_q, end_lo_d;
  logic [7:0]  din_q, din_d;
  logic        wait_q, wait_d;
  logic [15:0] addr_q, addr_d;
  logic        rd_q, rd_d;
  logic [15:0] fsize_q, fsize_d;
  logic        ready_q, ready_d;
  logic        bad_q, bad_d;
  logic        upload_q;
  logic        rise_s;
  logic [15:0] end_s;
  logic        bad_s;
  logic [15:0] len_s;

  assign rise_s = ioctl_upload & ~upload_q;
  // End pointer is complete in the same cycle its high byte arrives
  assign end_s  = {dma_din, end_lo_q};
  assign bad_s  = (end_s < start_q) | (end_s > RAM_TOP);
  assign len_s  = bad_s ? 16'h0000 : (end_s - start_q);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    lat_d    = lat_q;
    start_d  = start_q;
    end_lo_d = end_lo_q;
    din_d    = din_q;
    wait_d   = wait_q;
    addr_d   = addr_q;
    rd_d     = 1'b0;
    fsize_d  = fsize_q;
    ready_d  = ready_q;
    bad_d    = bad_q;
    if (!ioctl_upload) begin
      // Session over or aborted: any in-flight fetch result is dropped
      state_d = S_IDLE;
      wait_d  = 1'b0;
      ready_d = 1'b0;
      din_d   = 8'h00;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (rise_s) begin
            state_d = S_PTR;
            idx_d   = 2'd0;
            lat_d   = 8'd0;
            rd_d    = 1'b1;
            addr_d  = PTR_BASE;
            wait_d  = 1'b1;
            ready_d = 1'b0;
            bad_d   = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_PTR: begin
          if (lat_q == LAT) begin
            case (idx_q)
              2'd0:    start_d[7:0]  = dma_din;
              2'd1:    start_d[15:8] = dma_din;
              2'd2:    end_lo_d      = dma_din;
              default: end_lo_d      = end_lo_q;
            endcase
            if (idx_q == 2'd3) begin
              bad_d   = bad_s;
              fsize_d = len_s + 16'd2;
              ready_d = 1'b1;
              wait_d  = 1'b0;
              state_d = S_READY;
            end else begin
              idx_d  = idx_q + 2'd1;
              lat_d  = 8'd0;
              rd_d   = 1'b1;
              addr_d = PTR_BASE + {14'd0, idx_q} + 16'd1;
            end
          end else begin
            lat_d = lat_q + 8'd1;
          end
        end
        S_READY: begin
          if (ioctl_rd) begin
            wait_d = 1'b1;
            if ((ioctl_addr[24:16] != 9'd0) || (ioctl_addr[15:0] >= fsize_q)) begin
              din_d   = 8'h00;
              state_d = S_RESP;
            end else if (ioctl_addr[15:1] == 15'd0) begin
              din_d   = ioctl_addr[0] ? start_q[15:8] : start_q[7:0];
              state_d = S_RESP;
            end else begin
              addr_d  = start_q + ioctl_addr[15:0] - 16'd2;
              rd_d    = 1'b1;
              state_d = S_FETCH;
            end
          end else begin
            state_d = S_READY;
          end
        end
        S_FETCH: begin
          lat_d   = 8'd1;
          state_d = S_WAIT;
        end
        S_WAIT: begin
          if (lat_q >= LAT) begin
            din_d   = dma_din;
            wait_d  = 1'b0;
            state_d = S_READY;
          end else begin
            lat_d = lat_q + 8'd1;
          end
        end
        S_RESP: begin
          wait_d  = 1'b0;
          state_d = S_READY;
        end
        default: begin
          state_d = S_IDLE;
          wait_d  = 1'b0;
          ready_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      idx_q    <= 2'd0;
      lat_q    <= 8'd0;
      start_q  <= 16'h0000;
      end_lo_q <= 8'h00;
      din_q    <= 8'h00;
      wait_q   <= 1'b0;
      addr_q   <= 16'h0000;
      rd_q     <= 1'b0;
      fsize_q  <= 16'h0000;
      ready_q  <= 1'b0;
      bad_q    <= 1'b0;
      upload_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      lat_q    <= lat_d;
      start_q  <= start_d;
      end_lo_q <= end_lo_d;
      din_q    <= din_d;
      wait_q   <= wait_d;
      addr_q   <= addr_d;
      rd_q     <= rd_d;
      fsize_q  <= fsize_d;
      ready_q  <= ready_d;
      bad_q    <= bad_d;
      upload_q <= ioctl_upload;
    end
  end

  assign ioctl_din  = din_q;
  assign ioctl_wait = wait_q;
  assign dma_addr   = addr_q;
  assign dma_rd     = rd_q;
  assign file_size  = fsize_q;
  assign ready      = ready_q;
  assign bad_ptr    = bad_q;

`ifdef PRG_SAVE_CPU_HOLD_EN
  logic cpu_hold_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_hold_q <= 1'b0;
    end else begin
      cpu_hold_q <= ioctl_upload & (cpu_hold_q | rise_s);
    end
  end

  assign cpu_hold = cpu_hold_q;
`else
  assign cpu_hold = 1'b0;
`endif

endmodule
